// File: rtl/truth_table_sequencer.sv
// ---------------------------------------------------------------------------
// truth_table_sequencer
//
// Exhaustive-scan controller for a 4-input, 2-output combinational block.
// On a host start it drives {a,b,c,d} through all 16 minterms (a is the MSB
// of the vector index), holds each vector for SETTLE cycles, and samples the
// two function outputs into 16-bit truth tables. Any vector where the two
// outputs disagree is counted, and the index of the first disagreement is
// kept.
//
// Optional build macro:
//   MISMATCH_HALT_EN - when defined, the first mismatch ends the scan right
//                      after it is sampled; unscanned truth-table bits stay 0.
//
// Parameters:
//   SETTLE        cycles each vector is held before sampling (1..15)
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   start         scan request, only honoured in IDLE
//   a, b, c, d    registered vector outputs to the function block
//   f_in, f2_in   the two function outputs being compared
//   busy          high while a scan is in progress
//   done          one-cycle pulse when the scan completes
//   tt_f, tt_f2   captured truth tables, bit idx = output at vector idx
//   mismatch_cnt  number of vectors where f_in != f2_in (0..16)
//   first_mm      index of the first mismatch (valid when mm_valid = 1)
//   mm_valid      high once any mismatch has been recorded
//   equal         set after done when no mismatch was seen, held until start
// ---------------------------------------------------------------------------
module truth_table_sequencer #(
  parameter int unsigned SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  input  logic        f_in,
  input  logic        f2_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] tt_f,
  output logic [15:0] tt_f2,
  output logic [4:0]  mismatch_cnt,
  output logic [3:0]  first_mm,
  output logic        mm_valid,
  output logic        equal
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Terminal value of the settle counter; the sample happens in the cycle
  // where cnt reaches it, i.e. at the edge ending the vector's last cycle.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t      state;
  state_t      state_nxt;

  logic [3:0]  idx;
  logic [3:0]  cnt;
  logic [3:0]  vec;

  logic        start_scan;
  logic        sample;
  logic        advance;
  logic        finish;
  logic        mm_now;
  logic        last_vec;

  assign mm_now = f_in ^ f2_in;

`ifdef MISMATCH_HALT_EN
  // A mismatch ends the scan as if this were the final vector.
  assign last_vec = (idx == 4'hF) || mm_now;
`else
  assign last_vec = (idx == 4'hF);
`endif

  // Vector outputs come straight from a register so they only move on edges.
  assign a = vec[3];
  assign b = vec[2];
  assign c = vec[1];
  assign d = vec[0];

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // FSM next-state and control decode
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt  = state;
    busy       = 1'b0;
    done       = 1'b0;
    start_scan = 1'b0;
    sample     = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          start_scan = 1'b1;
          state_nxt  = SCAN;
        end
      end

      SCAN: begin
        busy = 1'b1;
        if (cnt == SETTLE_LAST) begin
          sample = 1'b1;
          if (last_vec) begin
            finish    = 1'b1;
            state_nxt = DONE;
          end else begin
            advance = 1'b1;
          end
        end
      end

      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Scan datapath: vector/settle counters, capture and mismatch bookkeeping
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      idx          <= 4'd0;
      cnt          <= 4'd0;
      vec          <= 4'd0;
      tt_f         <= 16'd0;
      tt_f2        <= 16'd0;
      mismatch_cnt <= 5'd0;
      first_mm     <= 4'd0;
      mm_valid     <= 1'b0;
      equal        <= 1'b0;
    end else begin
      if (start_scan) begin
        idx          <= 4'd0;
        cnt          <= 4'd0;
        vec          <= 4'd0;
        tt_f         <= 16'd0;
        tt_f2        <= 16'd0;
        mismatch_cnt <= 5'd0;
        first_mm     <= 4'd0;
        mm_valid     <= 1'b0;
        equal        <= 1'b0;
      end

      if (busy && !sample) begin
        cnt <= cnt + 4'd1;
      end

      if (sample) begin
        tt_f[idx]  <= f_in;
        tt_f2[idx] <= f2_in;
        if (mm_now) begin
          // At most 16 samples per scan, so the 5-bit count cannot wrap.
          mismatch_cnt <= mismatch_cnt + 5'd1;
          if (!mm_valid) begin
            first_mm <= idx;
            mm_valid <= 1'b1;
          end
        end
      end

      if (advance) begin
        idx <= idx + 4'd1;
        vec <= idx + 4'd1;
        cnt <= 4'd0;
      end

      // Leaving SCAN parks the vector at 0 for DONE and IDLE.
      if (finish) begin
        vec <= 4'd0;
      end

      // mismatch_cnt was updated by the final sample on the edge entering
      // DONE, so it already reflects every scanned vector here.
      if (done) begin
        equal <= (mismatch_cnt == 5'd0);
      end
    end
  end

endmodule

// File: tb/tb_truth_table_sequencer.sv
// ---------------------------------------------------------------------------
// tb_truth_table_sequencer
//
// Directed bench for truth_table_sequencer. Instance u1 uses SETTLE = 1 with
// a combinational function model f = a&b | c&d and f2 = f ^ mask[idx].
// Instance u3 uses SETTLE = 3 with f delayed by two clocks, so it only reads
// correctly when the vector is held for the full settle time.
// ---------------------------------------------------------------------------
module tb_truth_table_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic logic fmodel(input logic [3:0] v);
    return (v[3] & v[2]) | (v[1] & v[0]);
  endfunction

  // ---------------- instance 1: SETTLE = 1 ----------------
  logic        rst1, start1, a1, b1, c1, d1, f_1, f2_1, busy1, done1, mmv1, eq1;
  logic [15:0] ttf1, ttf2_1;
  logic [4:0]  mc1;
  logic [3:0]  fm1;
  logic [3:0]  vec1;
  logic [15:0] mask1 = 16'h0000;

  assign vec1 = {a1, b1, c1, d1};
  assign f_1  = fmodel(vec1);
  assign f2_1 = f_1 ^ mask1[vec1];

  truth_table_sequencer #(.SETTLE(1)) u1 (
    .clk(clk), .rst(rst1), .start(start1),
    .a(a1), .b(b1), .c(c1), .d(d1),
    .f_in(f_1), .f2_in(f2_1),
    .busy(busy1), .done(done1),
    .tt_f(ttf1), .tt_f2(ttf2_1),
    .mismatch_cnt(mc1), .first_mm(fm1), .mm_valid(mmv1), .equal(eq1)
  );

  // ---------------- instance 3: SETTLE = 3 ----------------
  logic        rst3, start3, a3, b3, c3, d3, f_3, f2_3, busy3, done3, mmv3, eq3;
  logic [15:0] ttf3, ttf2_3;
  logic [4:0]  mc3;
  logic [3:0]  fm3;
  logic [3:0]  vec3;
  logic        dly0 = 1'b0;
  logic        dly1 = 1'b0;

  assign vec3 = {a3, b3, c3, d3};
  always @(posedge clk) begin
    dly0 <= fmodel(vec3);
    dly1 <= dly0;
  end
  assign f_3  = dly1;
  assign f2_3 = fmodel(vec3);

  truth_table_sequencer #(.SETTLE(3)) u3 (
    .clk(clk), .rst(rst3), .start(start3),
    .a(a3), .b(b3), .c(c3), .d(d3),
    .f_in(f_3), .f2_in(f2_3),
    .busy(busy3), .done(done3),
    .tt_f(ttf3), .tt_f2(ttf2_3),
    .mismatch_cnt(mc3), .first_mm(fm3), .mm_valid(mmv3), .equal(eq3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Starts a scan on u1, checks the vector sequence while busy, and returns
  // the number of edges from the start edge until done is seen. Leaves the
  // bench one edge after the done cycle so equal is up to date.
  task automatic scan1(input logic [15:0] m, output int lat);
    mask1 = m;
    @(negedge clk) start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    chk("busy_after_start", {31'd0, busy1}, 32'd1);
    chk("vec_after_start", {28'd0, vec1}, 32'd0);
    lat = 0;
    while (!done1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (busy1) chk("vec_step", {28'd0, vec1}, lat);
    end
    if (!done1) chk("done_timeout", 32'd0, 32'd1);
    chk("busy_in_done", {31'd0, busy1}, 32'd0);
    chk("vec_in_done", {28'd0, vec1}, 32'd0);
    @(posedge clk);
    #1;
    chk("done_one_cycle", {31'd0, done1}, 32'd0);
  endtask

  typedef struct {
    logic [15:0] mask;
    logic [15:0] ttf;
    logic [15:0] ttf2;
    logic [4:0]  cnt;
    logic [3:0]  first;
    logic        mmv;
    logic        eq;
    int          lat;
  } vec_t;

  vec_t tbl[4];

  initial begin
    int lat;

    tbl[0] = '{16'h0000, 16'hF888, 16'hF888, 5'd0,  4'd0, 1'b0, 1'b1, 16};
`ifdef MISMATCH_HALT_EN
    tbl[1] = '{16'h0020, 16'h0008, 16'h0028, 5'd1,  4'd5, 1'b1, 1'b0, 6};
    tbl[2] = '{16'hFFFF, 16'h0000, 16'h0001, 5'd1,  4'd0, 1'b1, 1'b0, 1};
    tbl[3] = '{16'h4408, 16'h0008, 16'h0000, 5'd1,  4'd3, 1'b1, 1'b0, 4};
`else
    tbl[1] = '{16'h0020, 16'hF888, 16'hF8A8, 5'd1,  4'd5, 1'b1, 1'b0, 16};
    tbl[2] = '{16'hFFFF, 16'hF888, 16'h0777, 5'd16, 4'd0, 1'b1, 1'b0, 16};
    tbl[3] = '{16'h4408, 16'hF888, 16'hBC80, 5'd3,  4'd3, 1'b1, 1'b0, 16};
`endif

    rst1 = 1'b1; start1 = 1'b0;
    rst3 = 1'b1; start3 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy1}, 32'd0);
    chk("rst_done", {31'd0, done1}, 32'd0);
    chk("rst_vec", {28'd0, vec1}, 32'd0);
    chk("rst_ttf", {16'd0, ttf1}, 32'd0);
    chk("rst_ttf2", {16'd0, ttf2_1}, 32'd0);
    chk("rst_cnt", {27'd0, mc1}, 32'd0);
    chk("rst_first", {28'd0, fm1}, 32'd0);
    chk("rst_mmv", {31'd0, mmv1}, 32'd0);
    chk("rst_eq", {31'd0, eq1}, 32'd0);
    chk("rst_busy3", {31'd0, busy3}, 32'd0);
    @(negedge clk) begin rst1 = 1'b0; rst3 = 1'b0; end

    // Table-driven scans on the SETTLE = 1 instance.
    for (int i = 0; i < 4; i++) begin
      scan1(tbl[i].mask, lat);
      chk($sformatf("t%0d_latency", i), lat, tbl[i].lat);
      chk($sformatf("t%0d_tt_f", i), {16'd0, ttf1}, {16'd0, tbl[i].ttf});
      chk($sformatf("t%0d_tt_f2", i), {16'd0, ttf2_1}, {16'd0, tbl[i].ttf2});
      chk($sformatf("t%0d_mm_cnt", i), {27'd0, mc1}, {27'd0, tbl[i].cnt});
      chk($sformatf("t%0d_first_mm", i), {28'd0, fm1}, {28'd0, tbl[i].first});
      chk($sformatf("t%0d_mm_valid", i), {31'd0, mmv1}, {31'd0, tbl[i].mmv});
      chk($sformatf("t%0d_equal", i), {31'd0, eq1}, {31'd0, tbl[i].eq});
      repeat (2) @(posedge clk);
      #1;
      chk($sformatf("t%0d_hold_tt_f", i), {16'd0, ttf1}, {16'd0, tbl[i].ttf});
      chk($sformatf("t%0d_hold_equal", i), {31'd0, eq1}, {31'd0, tbl[i].eq});
    end

    // start held high: the second scan begins the cycle after done and
    // clears the first scan's results on that restart edge.
    begin
      int exp_lat;
`ifdef MISMATCH_HALT_EN
      exp_lat = 6;
`else
      exp_lat = 16;
`endif
      mask1 = 16'h0020;
      @(negedge clk) start1 = 1'b1;
      @(posedge clk);
      #1;
      lat = 0;
      while (!done1 && lat < 200) begin
        @(posedge clk);
        #1;
        lat++;
      end
      chk("b2b_first_latency", lat, exp_lat);
      chk("b2b_first_cnt", {27'd0, mc1}, 32'd1);
      @(posedge clk);
      #1;
      chk("b2b_idle_busy", {31'd0, busy1}, 32'd0);
      chk("b2b_idle_done", {31'd0, done1}, 32'd0);
      mask1 = 16'h0000;
      @(posedge clk);
      #1;
      chk("b2b_restart_busy", {31'd0, busy1}, 32'd1);
      chk("b2b_restart_cnt", {27'd0, mc1}, 32'd0);
      chk("b2b_restart_mmv", {31'd0, mmv1}, 32'd0);
      chk("b2b_restart_ttf", {16'd0, ttf1}, 32'd0);
      start1 = 1'b0;
      lat = 0;
      while (!done1 && lat < 200) begin
        @(posedge clk);
        #1;
        lat++;
      end
      chk("b2b_second_latency", lat, 16);
      @(posedge clk);
      #1;
      chk("b2b_second_ttf", {16'd0, ttf1}, 32'h0000F888);
      chk("b2b_second_equal", {31'd0, eq1}, 32'd1);
    end

    // Reset in the middle of a scan, then a fresh scan.
    mask1 = 16'h8000;
    @(negedge clk) start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("mid_vec", {28'd0, vec1}, 32'd7);
    chk("mid_ttf", {16'd0, ttf1}, 32'h00000008);
    @(negedge clk) rst1 = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_busy", {31'd0, busy1}, 32'd0);
    chk("midrst_done", {31'd0, done1}, 32'd0);
    chk("midrst_vec", {28'd0, vec1}, 32'd0);
    chk("midrst_ttf", {16'd0, ttf1}, 32'd0);
    chk("midrst_ttf2", {16'd0, ttf2_1}, 32'd0);
    chk("midrst_cnt", {27'd0, mc1}, 32'd0);
    chk("midrst_mmv", {31'd0, mmv1}, 32'd0);
    chk("midrst_eq", {31'd0, eq1}, 32'd0);
    @(negedge clk) rst1 = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_stays_idle", {31'd0, busy1}, 32'd0);
    scan1(16'h8000, lat);
    chk("post_rst_latency", lat, 16);
    chk("post_rst_ttf", {16'd0, ttf1}, 32'h0000F888);
    chk("post_rst_ttf2", {16'd0, ttf2_1}, 32'h00007888);
    chk("post_rst_cnt", {27'd0, mc1}, 32'd1);
    chk("post_rst_first", {28'd0, fm1}, 32'd15);
    chk("post_rst_eq", {31'd0, eq1}, 32'd0);

    // SETTLE = 3 with a two-clock-late f: each vector held three cycles.
    begin
      int busy_cycles;
      @(negedge clk) start3 = 1'b1;
      @(posedge clk);
      #1 start3 = 1'b0;
      lat = 0;
      busy_cycles = 0;
      while (!done3 && lat < 400) begin
        if (busy3) begin
          busy_cycles++;
          chk("s3_vec_hold", {28'd0, vec3}, (busy_cycles - 1) / 3);
        end
        @(posedge clk);
        #1;
        lat++;
      end
      chk("s3_latency", lat, 48);
      chk("s3_busy_cycles", busy_cycles, 48);
      chk("s3_busy_in_done", {31'd0, busy3}, 32'd0);
      @(posedge clk);
      #1;
      chk("s3_ttf", {16'd0, ttf3}, 32'h0000F888);
      chk("s3_ttf2", {16'd0, ttf2_3}, 32'h0000F888);
      chk("s3_cnt", {27'd0, mc3}, 32'd0);
      chk("s3_mmv", {31'd0, mmv3}, 32'd0);
      chk("s3_equal", {31'd0, eq3}, 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/truth_table_sequencer.md
# truth_table_sequencer

- Exhaustive-scan controller for a 4-input combinational function block with two outputs, f and f2. Typical pair: an SOP and a POS realisation of the same function.
- Steps the inputs {a,b,c,d} through all 16 minterms and holds each vector for a programmable settle time.
- Samples both outputs into 16-bit truth-table registers and reports mismatches between f and f2.
- Sits between a start/done host handshake and the function block; replaces hand-written per-vector stimulus.

## Interface

Parameters:
- SETTLE, default 1: cycles each vector is held before sampling; legal range 1..15.

Ports:
- clk  in  1  single system clock; everything is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  scan request; sampled only in IDLE.
- a, b, c, d  out  1 each  drive to the function block; vector index idx = {a,b,c,d}, with a as MSB.
- f_in  in  1  function output f.
- f2_in  in  1  function output f2.
- busy  out  1  high while a scan is in progress.
- done  out  1  one-cycle pulse when the scan completes.
- tt_f  out  16  captured f; bit idx = f at vector idx.
- tt_f2  out  16  captured f2; same bit mapping as tt_f.
- mismatch_cnt  out  5  number of vectors where f_in != f2_in; range 0..16.
- first_mm  out  4  idx of the first mismatch; valid only when mm_valid = 1.
- mm_valid  out  1  high once any mismatch has been recorded.
- equal  out  1  high after done when mismatch_cnt == 0; held until the next start.

## Operation

- FSM states: IDLE, SCAN, DONE.
- IDLE, start = 1:
  - Clear tt_f, tt_f2, mismatch_cnt, first_mm, mm_valid, equal.
  - Set idx = 0 and settle counter cnt = 0.
  - Go to SCAN.
- SCAN, each cycle:
  - Drive a..d = idx.
  - If cnt < SETTLE-1: cnt++.
  - Otherwise, sample:
    - tt_f[idx] <= f_in and tt_f2[idx] <= f2_in.
    - On a mismatch: mismatch_cnt++. If mm_valid = 0, also set first_mm <= idx and mm_valid <= 1.
    - Then, if idx == 15, go to DONE; otherwise idx++ and cnt = 0.
- DONE, exactly one cycle:
  - done = 1.
  - equal <= (final mismatch_cnt == 0). The value must include the last sample.
  - Go to IDLE.
- Results hold in IDLE until the next accepted start.
- a..d return to 0 in IDLE and DONE.
- start in SCAN or DONE is ignored; it is not queued.
- start held high continuously: a new scan begins on the first IDLE cycle after DONE.
- mismatch_cnt cannot exceed 16, so no saturation logic is required.

## Timing

- Reset values: a, b, c, d = 0; busy = 0; done = 0; tt_f = tt_f2 = 0; mismatch_cnt = 0; first_mm = 0; mm_valid = 0; equal = 0; state = IDLE.
- rst asserted mid-scan: all of the above apply at the next edge and the scan is abandoned.
- Edge E samples start = 1 in IDLE. From E+1, busy = 1 and a..d = 0.
- Each vector is held for SETTLE cycles. f_in/f2_in are sampled at the edge that ends the vector's last held cycle.
- busy stays high for 16·SETTLE cycles.
- done pulses in the cycle 16·SETTLE+1 after E. busy = 0 during the done cycle.
- Vector changes are registered outputs; they change only on clock edges.

## Configuration

- MISMATCH_HALT_EN defined:
  - The first mismatch ends the scan. After that sample the FSM goes to DONE instead of advancing.
  - mismatch_cnt = 1 and first_mm = failing idx.
  - tt bits for unscanned vectors remain 0.
  - done arrives (first_mm+1)·SETTLE+1 cycles after E.
- MISMATCH_HALT_EN undefined: always scan all 16 vectors; mismatch_cnt counts every mismatch.

## Test plan

- SETTLE = 1, f = f2 = a&b | c&d:
  - done pulses 17 cycles after the start edge.
  - tt_f = tt_f2 = 16'hF888, mismatch_cnt = 0, mm_valid = 0, equal = 1.
- f as above, f2 = f XOR (idx == 5):
  - tt_f2 = 16'hF8A8, mismatch_cnt = 1, first_mm = 5, mm_valid = 1, equal = 0.
- f2 = ~f:
  - Without the macro: mismatch_cnt = 16, first_mm = 0, tt_f2 = 16'h0777.
  - With MISMATCH_HALT_EN: done 2 cycles after the start edge, mismatch_cnt = 1.
- start held high throughout:
  - Pulses while busy are ignored.
  - A back-to-back scan begins the cycle after done, and results are cleared at that restart.
- rst asserted at cycle 8 of a scan:
  - The next edge shows all outputs at reset values and state IDLE.
  - A fresh start then gives correct results.
- SETTLE = 3:
  - Each vector is held 3 cycles.
  - busy lasts 48 cycles and done pulses 49 cycles after the start edge.
  - A function whose output changes in the cycle the vector is applied is still captured correctly.
